// File: rtl/hazard_stall_unit.sv
// Hazard detection and EX/MEM/WB destination tracking for the 5-stage MIPS pipeline.
// Issues stall/bubble/flush controls for the ID instruction and counts stall cycles.
module hazard_stall_unit #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             id_branch,
    input  logic             branch_taken,
    output logic             stall,
    output logic             bubble,
    output logic             flush_ifid,
    output logic [REG_W-1:0] ex_rd,
    output logic             ex_rw,
    output logic [REG_W-1:0] mem_rd,
    output logic             mem_rw,
    output logic [REG_W-1:0] wb_rd,
    output logic             wb_rw,
    output logic [CNT_W-1:0] stall_count
);

    // Slot index 0 = EX, 1 = MEM, 2 = WB. The WB load flag is never consulted.
    logic [REG_W-1:0] rd_reg [3];
    logic [2:0]       rw_reg;
    logic [1:0]       mr_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic [REG_W-1:0] ex_rd_next;
    logic             ex_rw_next;
    logic             ex_mr_next;
    logic [CNT_W-1:0] cnt_next;

    logic [1:0]       hit;
    logic             load_use;
    logic             branch_hazard;
    logic             stall_int;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_match
            assign hit[gi] = rw_reg[gi] && (rd_reg[gi] != '0) &&
                             ((id_uses_rs && (rd_reg[gi] == id_rs)) ||
                              (id_uses_rt && (rd_reg[gi] == id_rt)));
        end
    endgenerate

    assign load_use      = mr_reg[0] && hit[0];
    assign branch_hazard = id_branch && (hit[0] || (hit[1] && mr_reg[1]));
    assign stall_int     = id_valid && (load_use || branch_hazard);

    assign stall      = stall_int;
    assign bubble     = stall_int;
    assign flush_ifid = branch_taken && id_valid && !stall_int;

    always_comb begin
        ex_rd_next = '0;
        ex_rw_next = 1'b0;
        ex_mr_next = 1'b0;
        if (id_valid && !stall_int) begin
            ex_rd_next = id_rd;
            ex_rw_next = id_regwrite;
            ex_mr_next = id_memread;
        end
    end

    // Saturating stall counter: holds at all-ones instead of wrapping.
    always_comb begin
        cnt_next = cnt_reg;
        if (stall_int && (cnt_reg != '1)) begin
            cnt_next = cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_reg[0] <= '0;
            rd_reg[1] <= '0;
            rd_reg[2] <= '0;
            rw_reg    <= '0;
            mr_reg    <= '0;
            cnt_reg   <= '0;
        end else begin
            rd_reg[2] <= rd_reg[1];
            rd_reg[1] <= rd_reg[0];
            rd_reg[0] <= ex_rd_next;
            rw_reg    <= {rw_reg[1:0], ex_rw_next};
            mr_reg    <= {mr_reg[0], ex_mr_next};
            cnt_reg   <= cnt_next;
        end
    end

    assign ex_rd       = rd_reg[0];
    assign ex_rw       = rw_reg[0];
    assign mem_rd      = rd_reg[1];
    assign mem_rw      = rw_reg[1];
    assign wb_rd       = rd_reg[2];
    assign wb_rw       = rw_reg[2];
    assign stall_count = cnt_reg;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit (counter narrowed to 4 bits to reach saturation).
module tb_hazard_stall_unit;

    localparam int REG_W = 5;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic [REG_W-1:0] id_rd;
    logic             id_regwrite;
    logic             id_memread;
    logic             id_branch;
    logic             branch_taken;
    logic             stall;
    logic             bubble;
    logic             flush_ifid;
    logic [REG_W-1:0] ex_rd;
    logic             ex_rw;
    logic [REG_W-1:0] mem_rd;
    logic             mem_rw;
    logic [REG_W-1:0] wb_rd;
    logic             wb_rw;
    logic [CNT_W-1:0] stall_count;

    int checks   = 0;
    int failures = 0;

    hazard_stall_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_branch(id_branch), .branch_taken(branch_taken),
        .stall(stall), .bubble(bubble), .flush_ifid(flush_ifid),
        .ex_rd(ex_rd), .ex_rw(ex_rw), .mem_rd(mem_rd), .mem_rw(mem_rw),
        .wb_rd(wb_rd), .wb_rw(wb_rw), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic urs,
                          input logic [4:0] rt, input logic urt, input logic [4:0] rd,
                          input logic rw, input logic mr, input logic br, input logic tk);
        id_valid = v;   id_rs = rs;  id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
        id_rd = rd;     id_regwrite = rw; id_memread = mr; id_branch = br; branch_taken = tk;
        #1;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Advance one edge; inputs and checks happen 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (3) tick();
    endtask

    initial begin
        rst = 1'b0;
        idle();
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("rst_ex_rd", 32'(ex_rd), 0);
        check("rst_ex_rw", 32'(ex_rw), 0);
        check("rst_mem_rw", 32'(mem_rw), 0);
        check("rst_wb_rw", 32'(wb_rw), 0);
        check("rst_stall", 32'(stall), 0);
        check("rst_flush", 32'(flush_ifid), 0);
        check("rst_count", 32'(stall_count), 0);

        // lw $8 then add using $8
        set_id(1, 5'd0, 0, 5'd0, 0, 5'd8, 1, 1, 0, 0);
        check("lw_nostall", 32'(stall), 0);
        tick();
        set_id(1, 5'd8, 1, 5'd3, 1, 5'd11, 1, 0, 0, 0);
        check("lu_stall", 32'(stall), 1);
        check("lu_bubble", 32'(bubble), 1);
        check("lu_ex_rd", 32'(ex_rd), 8);
        tick();
        check("lu_stall_end", 32'(stall), 0);
        check("lu_mem_rd", 32'(mem_rd), 8);
        check("lu_mem_rw", 32'(mem_rw), 1);
        check("lu_ex_bubble", 32'(ex_rw), 0);
        check("lu_count", 32'(stall_count), 1);
        tick();
        check("lu_add_ex_rd", 32'(ex_rd), 11);
        check("lu_add_ex_rw", 32'(ex_rw), 1);
        check("lu_wb_rd", 32'(wb_rd), 8);
        check("lu_wb_rw", 32'(wb_rw), 1);
        drain();
        check("drain_ex_rw", 32'(ex_rw), 0);

        // add $9 then taken beq using $9
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd9, 1, 0, 0, 0);
        check("add_nostall", 32'(stall), 0);
        tick();
        set_id(1, 5'd9, 1, 5'd0, 1, 5'd0, 0, 0, 1, 1);
        check("alubr_stall", 32'(stall), 1);
        check("alubr_noflush", 32'(flush_ifid), 0);
        tick();
        check("alubr_stall_end", 32'(stall), 0);
        check("alubr_flush", 32'(flush_ifid), 1);
        check("alubr_count", 32'(stall_count), 2);
        tick();
        idle();
        check("alubr_flush_idle", 32'(flush_ifid), 0);
        drain();

        // lw $10 then beq using rt=$10: two stall cycles
        set_id(1, 5'd0, 0, 5'd0, 0, 5'd10, 1, 1, 0, 0);
        tick();
        set_id(1, 5'd0, 0, 5'd10, 1, 5'd0, 0, 0, 1, 0);
        check("ldbr_stall1", 32'(stall), 1);
        tick();
        check("ldbr_stall2", 32'(stall), 1);
        check("ldbr_mem_rd", 32'(mem_rd), 10);
        tick();
        check("ldbr_stall_end", 32'(stall), 0);
        check("ldbr_count", 32'(stall_count), 4);
        tick();
        drain();

        // Writer to $0 never creates a hazard; regwrite=0 ignores id_rd
        set_id(1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 1, 0, 0);
        tick();
        set_id(1, 5'd0, 1, 5'd0, 1, 5'd5, 0, 0, 1, 0);
        check("zero_nostall", 32'(stall), 0);
        tick();
        idle();
        check("nowrite_ex_rw", 32'(ex_rw), 0);
        check("zero_mem_rw", 32'(mem_rw), 1);
        check("zero_mem_rd", 32'(mem_rd), 0);
        check("zero_count", 32'(stall_count), 4);
        drain();

        // 19 more load-use stalls: 4 + 19 would wrap a 4-bit counter
        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            set_id(1, 5'd0, 0, 5'd0, 0, 5'd8, 1, 1, 0, 0);
            tick();
            set_id(1, 5'd8, 1, 5'd0, 0, 5'd12, 1, 0, 0, 0);
            tick();
            tick();
        end
        check("sat_count", 32'(stall_count), 15);

        // Reset asserted while a stall is pending
        set_id(1, 5'd0, 0, 5'd0, 0, 5'd8, 1, 1, 0, 0);
        tick();
        set_id(1, 5'd8, 1, 5'd0, 0, 5'd12, 1, 0, 0, 0);
        check("midrst_stall_before", 32'(stall), 1);
        rst = 1'b0;
        tick();
        check("midrst_ex_rw", 32'(ex_rw), 0);
        check("midrst_ex_rd", 32'(ex_rd), 0);
        check("midrst_mem_rw", 32'(mem_rw), 0);
        check("midrst_mem_rd", 32'(mem_rd), 0);
        check("midrst_wb_rw", 32'(wb_rw), 0);
        check("midrst_wb_rd", 32'(wb_rd), 0);
        check("midrst_count", 32'(stall_count), 0);
        check("midrst_stall", 32'(stall), 0);
        rst = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
